bkg_ram_scheduler: RTL and testbench

//  Sequencer and arbiter for the 160x160x24b background RAM (1-cycle registered read, single write port).

---
 rtl/bkg_ram_scheduler.sv | 140 ++++++++++++++
 tb/tb_bkg_ram_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bkg_ram_scheduler.sv
// Background RAM sequencer: scaled/scrolled VGA read address generation, plus a
// write port shared between a host single-word writer and a full-screen fill engine.
module bkg_ram_scheduler #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 160,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24,
  parameter int SHIFT  = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [7:0]        scroll_y,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] pixel_rgb,
  output logic              pixel_vld
);
  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] NPIX   = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] IMG_WA = ADDR_W'(IMG_W);
  localparam logic [9:0]        IMG_HR = 10'(IMG_H);
  localparam logic [7:0]        SCR_LIM = 8'(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_lat_q, fill_lat_d;
  logic [7:0]          scroll_lat_q, scroll_lat_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [STAGES:0]     vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0]   rgb_q, rgb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [9:0]          row_raw, row, col;

  // Read path: address at stage 0, RAM registers at stage 1, colour captured at stage 2.
  always_comb begin
    row_raw      = (DrawY >> SHIFT) + {2'b00, scroll_lat_q};
    row          = (row_raw >= IMG_HR) ? row_raw - IMG_HR : row_raw;
    col          = DrawX >> SHIFT;
    raddr_d      = ADDR_W'(row) * IMG_WA + ADDR_W'(col);
    scroll_lat_d = scroll_lat_q;
    if (frame_start) scroll_lat_d = (scroll_y < SCR_LIM) ? scroll_y : 8'd0;
    vld_pipe_d   = {vld_pipe_q[STAGES-1:0], pix_valid};
    rgb_d        = vld_pipe_q[STAGES-1] ? ram_rdata : '0;
  end

  // Write arbitration: fill wins over the host; host writes are registered one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_lat_d = fill_lat_q;
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    wr_ack     = 1'b0;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d    = FILL;
          cnt_d      = '0;
          fill_lat_d = fill_color;
        end else if (wr_req) begin
          wr_ack = 1'b1;
          if (wr_addr < NPIX) begin
            we_d    = 1'b1;
            waddr_d = wr_addr;
            wdata_d = wr_data;
          end
        end
      end
      FILL: begin
        fill_busy = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_lat_q   <= '0;
      scroll_lat_q <= '0;
      raddr_q      <= '0;
      vld_pipe_q   <= '0;
      rgb_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_lat_q   <= fill_lat_d;
      scroll_lat_q <= scroll_lat_d;
      raddr_q      <= raddr_d;
      vld_pipe_q   <= vld_pipe_d;
      rgb_q        <= rgb_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Fill writes drive the port directly from the counter; a host write can never
  // be pending in FILL because fill_start blocks the ack in the same cycle.
  assign ram_we    = (state_q == FILL) | we_q;
  assign ram_waddr = (state_q == FILL) ? cnt_q : waddr_q;
  assign ram_wdata = (state_q == FILL) ? fill_lat_q : wdata_q;
  assign ram_raddr = raddr_q;
  assign pixel_rgb = rgb_q;
  assign pixel_vld = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_bkg_ram_scheduler.sv
// Bench for bkg_ram_scheduler: behavioural RAM, randomized reads/writes against an
// arithmetic screen-to-texel model, plus directed fill / reset / edge cases.
module tb_bkg_ram_scheduler;
  localparam int NPIX = 160 * 160;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, pix_valid, wr_req, fill_start;
  logic [7:0]  scroll_y;
  logic [9:0]  DrawX, DrawY;
  logic [14:0] wr_addr;
  logic [23:0] wr_data, fill_color;
  logic        wr_ack, fill_busy, fill_done, ram_we, pixel_vld;
  logic [14:0] ram_raddr, ram_waddr;
  logic [23:0] ram_rdata, ram_wdata, pixel_rgb;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [0:NPIX-1];
  bit          written [0:NPIX-1];

  always #5 Clk = ~Clk;

  bkg_ram_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .scroll_y(scroll_y),
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .pixel_rgb(pixel_rgb), .pixel_vld(pixel_vld)
  );

  function automatic logic [23:0] init_val(int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:8];
  endfunction

  function automatic logic [23:0] rd_model(int a);
    if (a < 0 || a >= NPIX) return 24'd0;
    return written[a] ? mem[a] : init_val(a);
  endfunction

  // Registered-read RAM; same-edge read sees the old word.
  always @(posedge Clk) begin
    if (ram_we && int'(ram_waddr) < NPIX) begin
      mem[ram_waddr]     <= ram_wdata;
      written[ram_waddr] <= 1'b1;
    end
    ram_rdata <= rd_model(int'(ram_raddr));
  end

  function automatic int texel_addr(int dx, int dy, int scr);
    return (((dy / 4) + scr) % 160) * 160 + dx / 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_rd(input int dx, input int dy, input logic pv, input logic fs, input int sy);
    DrawX = 10'(dx); DrawY = 10'(dy); pix_valid = pv; frame_start = fs; scroll_y = 8'(sy);
  endtask

  int          ea [0:399];
  bit          ev [0:399];
  int          m_scroll;
  int          bad, dx, dy, sy;
  bit          req, pv, fs;
  logic [14:0] a;
  logic [23:0] d, col;

  initial begin
    Reset_n = 1'b0; frame_start = 0; pix_valid = 0; wr_req = 0; fill_start = 0;
    scroll_y = 0; DrawX = 0; DrawY = 0; wr_addr = 0; wr_data = 0; fill_color = 0;
    step(); step();
    Reset_n = 1'b1;
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_rgb", pixel_rgb, 0);
    chk("rst_vld", pixel_vld, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);

    // Address map and 2-stage latency
    drive_rd(4, 8, 1, 0, 0); step();
    chk("map_raddr", ram_raddr, 321);
    drive_rd(0, 0, 0, 0, 0); step(); step();
    chk("map_rgb", pixel_rgb, rd_model(321));
    chk("map_vld", pixel_vld, 1);
    step();
    chk("nv_rgb", pixel_rgb, 0);
    chk("nv_vld", pixel_vld, 0);

    // Scroll wrap and frame latch
    drive_rd(0, 400, 1, 1, 100); step();
    drive_rd(0, 400, 1, 0, 5); step();
    chk("wrap_raddr", ram_raddr, 6400);
    step();
    chk("latch_raddr", ram_raddr, 6400);
    drive_rd(0, 400, 1, 1, 200); step();
    drive_rd(0, 400, 1, 0, 0); step();
    chk("oor_scroll", ram_raddr, 16000);
    drive_rd(0, 0, 0, 0, 0);

    // Host write and readback
    wr_req = 1; wr_addr = 15'd5; wr_data = 24'hFF0000;
    #1 chk("wr_ack", wr_ack, 1);
    step();
    wr_req = 0;
    chk("wr_we", ram_we, 1);
    chk("wr_waddr", ram_waddr, 5);
    chk("wr_wdata", ram_wdata, 24'hFF0000);
    drive_rd(20, 0, 1, 0, 0); step();
    drive_rd(0, 0, 0, 0, 0); step(); step();
    chk("wr_readback", pixel_rgb, 24'hFF0000);

    // Out-of-range write: acked, dropped
    wr_req = 1; wr_addr = 15'd25600; wr_data = 24'h123456;
    #1 chk("oor_ack", wr_ack, 1);
    step();
    wr_req = 0;
    chk("oor_we", ram_we, 0);

    // Randomized host writes
    for (int k = 0; k < 300; k++) begin
      req = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 9) == 0) ? 15'(25600 + $urandom_range(0, 7167)) : 15'($urandom_range(0, NPIX - 1));
      d = 24'($urandom);
      wr_req = req; wr_addr = a; wr_data = d;
      #1 chk("rw_ack", wr_ack, 32'(req));
      step();
      chk("rw_we", ram_we, 32'(req && int'(a) < NPIX));
      if (req && int'(a) < NPIX) begin
        chk("rw_waddr", ram_waddr, a);
        chk("rw_wdata", ram_wdata, d);
      end
    end
    wr_req = 0;
    step();

    // Randomized reads with random frame_start / scroll
    m_scroll = 0;
    for (int n = 0; n < 400; n++) begin
      dx = $urandom_range(0, 639); dy = $urandom_range(0, 479);
      pv = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 19) == 0);
      sy = $urandom_range(0, 255);
      drive_rd(dx, dy, pv, fs, sy);
      ea[n] = texel_addr(dx, dy, m_scroll);
      ev[n] = pv;
      if (fs) m_scroll = (sy < 160) ? sy : 0;
      step();
      chk("rr_raddr", ram_raddr, ea[n]);
      if (n >= 2) begin
        chk("rr_vld", pixel_vld, 32'(ev[n-2]));
        chk("rr_rgb", pixel_rgb, ev[n-2] ? rd_model(ea[n-2]) : 24'd0);
      end
    end
    drive_rd(0, 0, 0, 0, 0);

    // Full fill, host request raised simultaneously
    col = 24'h00FF00;
    fill_start = 1; fill_color = col; wr_req = 1; wr_addr = 15'd77; wr_data = 24'hABCDEF;
    #1 chk("fill_vs_wr_ack", wr_ack, 0);
    step();
    fill_start = 0;
    chk("fill_busy", fill_busy, 1);
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (!(ram_we && int'(ram_waddr) == i && ram_wdata == col && fill_busy && !fill_done && !wr_ack)) bad++;
      step();
    end
    chk("fill_seq_bad", bad, 0);
    chk("done_pulse", fill_done, 1);
    chk("done_we", ram_we, 0);
    chk("done_ack", wr_ack, 0);
    step();
    chk("done_once", fill_done, 0);
    chk("post_busy", fill_busy, 0);
    chk("post_ack", wr_ack, 1);
    step();
    wr_req = 0;
    chk("post_we", ram_we, 1);
    chk("post_waddr", ram_waddr, 77);
    drive_rd($urandom_range(0, 639), $urandom_range(8, 479), 1, 0, 0); step();
    drive_rd(0, 0, 0, 0, 0); step(); step();
    chk("fill_readback", pixel_rgb, col);

    // Reset mid-fill, then restart from 0
    drive_rd(0, 0, 1, 0, 0);
    fill_start = 1; fill_color = 24'h0000FF; step();
    fill_start = 0;
    for (int i = 0; i < 1000; i++) step();
    chk("mid_waddr", ram_waddr, 1000);
    Reset_n = 0; step();
    chk("rstf_we", ram_we, 0);
    chk("rstf_busy", fill_busy, 0);
    chk("rstf_rgb", pixel_rgb, 0);
    Reset_n = 1; fill_start = 1; step();
    fill_start = 0;
    chk("restart_we", ram_we, 1);
    chk("restart_waddr", ram_waddr, 0);
    Reset_n = 0; step();
    Reset_n = 1; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
